i2c_bus_mon: RTL

I2C_BUS_MON -- requirements
Module: i2c_bus_mon

---
 rtl/i2c_bus_mon.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_bus_mon.sv
// i2c_bus_mon: passive I2C monitor - pad sync, glitch filter, START/STOP, bit count.
// Define I2C_BUS_MON_TIMEOUT_EN to build the SCL-low timeout counter.
module i2c_bus_mon #(
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  input  logic [CNT_W-1:0] debounce_cnt,
  input  logic [TO_W-1:0]  timeout_cyc,
  output logic             scl_f,
  output logic             sda_f,
  output logic             scl_rise,
  output logic             scl_fall,
  output logic             start_det,
  output logic             rstart_det,
  output logic             stop_det,
  output logic             bus_busy,
  output logic [3:0]       bit_cnt,
  output logic             ack_strobe,
  output logic             ack_bit,
  output logic             scl_timeout
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state_q;
  state_t state_d;

  logic scl_s1;
  logic scl_s2;
  logic sda_s1;
  logic sda_s2;

  logic [CNT_W-1:0] scl_cnt;
  logic [CNT_W-1:0] sda_cnt;

  logic scl_prev;
  logic sda_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
    end
  end

  // Filter commits only after debounce_cnt+1 consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_cnt <= '0;
      scl_f   <= 1'b1;
    end else if (scl_s2 == scl_f) begin
      scl_cnt <= '0;
    end else if (scl_cnt == debounce_cnt) begin
      scl_cnt <= '0;
      scl_f   <= scl_s2;
    end else begin
      scl_cnt <= scl_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_cnt <= '0;
      sda_f   <= 1'b1;
    end else if (sda_s2 == sda_f) begin
      sda_cnt <= '0;
    end else if (sda_cnt == debounce_cnt) begin
      sda_cnt <= '0;
      sda_f   <= sda_s2;
    end else begin
      sda_cnt <= sda_cnt + CNT_W'(1);
    end
  end

  logic rise_c;
  logic fall_c;
  logic start_c;
  logic stop_c;
  logic start_n;
  logic rstart_n;
  logic stop_n;
  logic ack_n;
  logic ack_bit_d;
  logic [3:0] bit_cnt_d;

  always_comb begin
    rise_c    = scl_f & ~scl_prev;
    fall_c    = ~scl_f & scl_prev;
    start_c   = scl_f & scl_prev & sda_prev & ~sda_f;
    stop_c    = scl_f & scl_prev & ~sda_prev & sda_f;
    state_d   = state_q;
    bit_cnt_d = bit_cnt;
    ack_bit_d = ack_bit;
    start_n   = 1'b0;
    rstart_n  = 1'b0;
    stop_n    = 1'b0;
    ack_n     = 1'b0;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = 4'd0;
        if (start_c) begin
          state_d = BUSY;
          start_n = 1'b1;
        end
      end
      BUSY: begin
        if (start_c) begin
          rstart_n  = 1'b1;
          bit_cnt_d = 4'd0;
        end else if (stop_c) begin
          state_d   = IDLE;
          stop_n    = 1'b1;
          bit_cnt_d = 4'd0;
        end else if (rise_c) begin
          if (bit_cnt == 4'd8) begin
            bit_cnt_d = 4'd0;
            ack_n     = 1'b1;
            ack_bit_d = sda_f;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      scl_prev   <= 1'b1;
      sda_prev   <= 1'b1;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      bit_cnt    <= 4'd0;
      ack_strobe <= 1'b0;
      ack_bit    <= 1'b1;
    end else begin
      state_q    <= state_d;
      scl_prev   <= scl_f;
      sda_prev   <= sda_f;
      scl_rise   <= rise_c;
      scl_fall   <= fall_c;
      start_det  <= start_n;
      rstart_det <= rstart_n;
      stop_det   <= stop_n;
      bit_cnt    <= bit_cnt_d;
      ack_strobe <= ack_n;
      ack_bit    <= ack_bit_d;
    end
  end

  assign bus_busy = (state_q == BUSY);

`ifdef I2C_BUS_MON_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_nxt;
  logic            to_fired;

  assign to_nxt = (&to_cnt) ? to_cnt : to_cnt + TO_W'(1);

  // One pulse per low phase; re-armed only when SCL goes high or bus idles
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      to_fired    <= 1'b0;
      scl_timeout <= 1'b0;
    end else begin
      scl_timeout <= 1'b0;
      if (state_q != BUSY || scl_f) begin
        to_cnt   <= '0;
        to_fired <= 1'b0;
      end else begin
        to_cnt <= to_nxt;
        if (!to_fired && timeout_cyc != '0
            && to_nxt == timeout_cyc) begin
          scl_timeout <= 1'b1;
          to_fired    <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cyc;
  assign scl_timeout    = 1'b0;
`endif

endmodule
